// File: rtl/power_sum_seq.sv
// power_sum_seq: sequential power-sum unit.
// Computes result = sum(x_k ^ e) over a streamed operand list using a single
// WIDTH x WIDTH multiply per clock. Operands arrive on a valid/ready stream;
// a job is launched with start and finishes with a one-cycle done pulse.
// error[0] flags arithmetic overflow (power or sum), error[1] flags that the
// term limit was reached before in_last was seen.
module power_sum_seq #(
    parameter int WIDTH     = 32,
    parameter int EXP_W     = 4,
    parameter int MAX_TERMS = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [EXP_W-1:0]                 exp,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 in_data,
    input  logic                             in_last,
    output logic [WIDTH-1:0]                 result,
    output logic                             done,
    output logic                             busy,
    output logic [1:0]                       error,
    output logic [$clog2(MAX_TERMS+1)-1:0]   term_count
);

    localparam int TC_W = $clog2(MAX_TERMS + 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        POW  = 3'd2,
        ACC  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t             state_q;
    logic [EXP_W-1:0]   exp_q;
    logic [EXP_W-1:0]   pow_cnt_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   pow_q;
    logic [WIDTH-1:0]   acc_q;
    logic               last_q;
    logic               ovf_q;
    logic               lim_q;
    logic [TC_W-1:0]    tc_q;
    logic [WIDTH-1:0]   result_q;
    logic [1:0]         error_q;
    logic               done_q;
    logic               busy_q;
    logic               in_ready_q;

    // Datapath next values: full-width product and carry-extended sum.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   pow_d;
    logic [WIDTH-1:0]   acc_d;
    logic               pow_ovf;
    logic               acc_carry;
    logic [TC_W-1:0]    tc_d;
    logic               at_limit;

    // Multiply/add units and the term-limit compare feeding the FSM.
    always_comb begin
        prod      = {{WIDTH{1'b0}}, pow_q} * {{WIDTH{1'b0}}, x_q};
        sum       = {1'b0, acc_q} + {1'b0, pow_q};
        pow_d     = prod[WIDTH-1:0];
        pow_ovf   = |prod[2*WIDTH-1:WIDTH];
        acc_d     = sum[WIDTH-1:0];
        acc_carry = sum[WIDTH];
        tc_d      = tc_q + TC_W'(1);
        at_limit  = (tc_d == TC_W'(MAX_TERMS));
    end

    // Control FSM with all outputs registered; reset discards any partial job.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            exp_q      <= '0;
            pow_cnt_q  <= '0;
            x_q        <= '0;
            pow_q      <= '0;
            acc_q      <= '0;
            last_q     <= 1'b0;
            ovf_q      <= 1'b0;
            lim_q      <= 1'b0;
            tc_q       <= '0;
            result_q   <= '0;
            error_q    <= 2'b00;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // start is ignored everywhere else, so busy jobs never restart
                    if (start) begin
                        exp_q      <= exp;
                        acc_q      <= '0;
                        tc_q       <= '0;
                        ovf_q      <= 1'b0;
                        lim_q      <= 1'b0;
                        busy_q     <= 1'b1;
                        in_ready_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        x_q        <= in_data;
                        pow_q      <= WIDTH'(1);
                        pow_cnt_q  <= exp_q;
                        tc_q       <= tc_d;
                        last_q     <= in_last | at_limit;
                        if (at_limit && !in_last) lim_q <= 1'b1;
                        in_ready_q <= 1'b0;
                        // exp=0 skips POW, so the term is 1 even for x=0
                        state_q    <= (exp_q != '0) ? POW : ACC;
                    end
                end
                POW: begin
                    pow_q     <= pow_d;
                    if (pow_ovf) ovf_q <= 1'b1;
                    pow_cnt_q <= pow_cnt_q - EXP_W'(1);
                    if (pow_cnt_q == EXP_W'(1)) state_q <= ACC;
                end
                ACC: begin
                    acc_q <= acc_d;
                    if (acc_carry) ovf_q <= 1'b1;
                    if (last_q) begin
                        // publish now so result/error are valid alongside done
                        result_q <= acc_d;
                        error_q  <= {lim_q, ovf_q | acc_carry};
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= LOAD;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign result     = result_q;
    assign done       = done_q;
    assign busy       = busy_q;
    assign error      = error_q;
    assign term_count = tc_q;

endmodule
